// File: rtl/slave_regfile_ws.sv
// Wait-state register-file bus responder: word-addressed registers answered after WAIT_CYCLES.
// Optional build macro SLAVE_RO_ID_EN makes index 0 a read-only ID register with no storage.
module slave_regfile_ws #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 16,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] ID_VALUE    = 32'h5157_0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int IDX_W = $clog2(NUM_REGS);
`ifdef SLAVE_RO_ID_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(4 * NUM_REGS);
    localparam logic [3:0]      CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               load_cap;

    logic               cap_we, cap_ok;
    logic [IDX_W-1:0]   cap_idx;
    logic [DATA_W-1:0]  cap_wdata;

    logic               cur_we, cur_ok;
    logic [IDX_W-1:0]   cur_idx;
    logic [DATA_W-1:0]  cur_wdata;

    logic [DATA_W-1:0]  regs [NUM_REGS-1:FIRST];

    function automatic logic access_ok(input logic [ADDR_W-1:0] a, input logic w);
        logic ok;
        ok = (a[1:0] == 2'b00) && ({1'b0, a} < ADDR_LIM);
`ifdef SLAVE_RO_ID_EN
        if (w && (a[IDX_W+1:2] == '0))
            ok = 1'b0;
`else
        if (w) ok = ok;
`endif
        return ok;
    endfunction

    function automatic logic [DATA_W-1:0] read_reg(input logic [IDX_W-1:0] i);
`ifdef SLAVE_RO_ID_EN
        if (i == '0)
            return ID_VALUE;
`endif
        return regs[i];
    endfunction

    // In IDLE the live request drives decode so a zero-wait build can respond on the sample edge.
    always_comb begin
        if (state == IDLE) begin
            cur_we    = we;
            cur_ok    = access_ok(addr, we);
            cur_idx   = addr[IDX_W+1:2];
            cur_wdata = wdata;
        end else begin
            cur_we    = cap_we;
            cur_ok    = cap_ok;
            cur_idx   = cap_idx;
            cur_wdata = cap_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_cap  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    load_cap = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end else begin
                        state_nxt = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0)
                    state_nxt = RESP;
                else
                    cnt_nxt = cnt - 4'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Request capture: data-only registers, no reset needed.
    always_ff @(posedge clk) begin
        if (load_cap) begin
            cap_we    <= cur_we;
            cap_ok    <= cur_ok;
            cap_idx   <= cur_idx;
            cap_wdata <= cur_wdata;
        end
    end

    // Response registers load on the edge entering RESP, so ready/rdata/err are flop outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= (state_nxt == RESP);
            err   <= (state_nxt == RESP) && !cur_ok;
            rdata <= ((state_nxt == RESP) && cur_ok && !cur_we) ? read_reg(cur_idx) : '0;
        end
    end

    // Write commit on the RESP edge; reset takes priority and discards a pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = FIRST; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if ((state == RESP) && cap_ok && cap_we) begin
            regs[cap_idx] <= cap_wdata;
        end
    end

endmodule

// File: tb/tb_slave_regfile_ws.sv
// Directed self-checking bench for slave_regfile_ws: a WAIT_CYCLES=2 instance and a zero-wait instance.
module tb_slave_regfile_ws;

    logic        clk;
    logic        reset;
    logic        req_a, we_a, ready_a, err_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a, rdata_a;
    logic        req_z, we_z, ready_z, err_z;
    logic [7:0]  addr_z;
    logic [31:0] wdata_z, rdata_z;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    slave_regfile_ws #(.WAIT_CYCLES(2)) u_ws (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a),
        .wdata(wdata_a), .ready(ready_a), .rdata(rdata_a), .err(err_a)
    );

    slave_regfile_ws #(.WAIT_CYCLES(0)) u_zw (
        .clk(clk), .reset(reset), .req(req_z), .we(we_z), .addr(addr_z),
        .wdata(wdata_z), .ready(ready_z), .rdata(rdata_z), .err(err_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input bit zw);
        return zw ? ready_z : ready_a;
    endfunction

    // Issue one transaction; returns edges from sample edge to ready (bounded) and response fields.
    task automatic txn(input bit zw, input logic w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic e, output int lat);
        if (zw) begin req_z = 1'b1; we_z = w; addr_z = a; wdata_z = d; end
        else    begin req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d; end
        @(posedge clk); #1;
        lat = 0;
        while (!rdy(zw) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = zw ? rdata_z : rdata_a;
        e  = zw ? err_z : err_a;
        if (zw) req_z = 1'b0; else req_a = 1'b0;
        @(posedge clk); #1;
        chk("ready_one_cycle", 32'(rdy(zw)), 32'd0);
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat, t1, t2, seen;

    initial begin
        reset = 1'b1;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_z = 1'b0; we_z = 1'b0; addr_z = '0; wdata_z = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(ready_a), 32'd0);
        chk("reset_rdata", rdata_a, 32'd0);
        chk("reset_err", 32'(err_a), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        txn(1'b0, 1'b1, 8'h04, 32'hDEADBEEF, rd, e, lat);
        chk("wr04_latency", 32'(lat), 32'd2);
        chk("wr04_err", 32'(e), 32'd0);
        chk("wr04_rdata", rd, 32'd0);
        txn(1'b0, 1'b0, 8'h04, 32'h0, rd, e, lat);
        chk("rd04_latency", 32'(lat), 32'd2);
        chk("rd04_err", 32'(e), 32'd0);
        chk("rd04_rdata", rd, 32'hDEADBEEF);
        chk("idle_rdata_zero", rdata_a, 32'd0);

        txn(1'b0, 1'b1, 8'h05, 32'h1111_1111, rd, e, lat);
        chk("wr05_misaligned_err", 32'(e), 32'd1);
        txn(1'b0, 1'b1, 8'h40, 32'h2222_2222, rd, e, lat);
        chk("wr40_range_err", 32'(e), 32'd1);
        txn(1'b0, 1'b0, 8'h04, 32'h0, rd, e, lat);
        chk("rd04_unchanged", rd, 32'hDEADBEEF);
        txn(1'b0, 1'b0, 8'h06, 32'h0, rd, e, lat);
        chk("rd06_err", 32'(e), 32'd1);
        chk("rd06_rdata_zero", rd, 32'd0);

        req_a = 1'b1; we_a = 1'b1; addr_a = 8'h08; wdata_a = 32'h1234_5678;
        @(posedge clk); #1;
        reset = 1'b1; req_a = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ready_a) seen = 1;
        end
        chk("abort_no_ready", 32'(seen), 32'd0);
        txn(1'b0, 1'b0, 8'h08, 32'h0, rd, e, lat);
        chk("rd08_after_abort", rd, 32'd0);
        txn(1'b0, 1'b0, 8'h04, 32'h0, rd, e, lat);
        chk("rd04_cleared_by_reset", rd, 32'd0);

        req_a = 1'b1; we_a = 1'b1; addr_a = 8'h0C; wdata_a = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        t1 = -1;
        for (int k = 0; k < 20 && t1 < 0; k++) begin
            if (ready_a) t1 = cyc;
            else begin @(posedge clk); #1; end
        end
        we_a = 1'b0;
        @(posedge clk); #1;
        t2 = -1;
        for (int k = 0; k < 20 && t2 < 0; k++) begin
            if (ready_a) t2 = cyc;
            else begin @(posedge clk); #1; end
        end
        chk("b2b_spacing", 32'(t2 - t1), 32'd4);
        chk("b2b_first_seen", 32'(t1 >= 0), 32'd1);
        chk("b2b_rdata", rdata_a, 32'hA5A5_A5A5);
        req_a = 1'b0;
        @(posedge clk); #1;

`ifdef SLAVE_RO_ID_EN
        txn(1'b0, 1'b0, 8'h00, 32'h0, rd, e, lat);
        chk("rd00_id", rd, 32'h5157_0001);
        chk("rd00_err", 32'(e), 32'd0);
        txn(1'b0, 1'b1, 8'h00, 32'hFFFF_FFFF, rd, e, lat);
        chk("wr00_ro_err", 32'(e), 32'd1);
        txn(1'b0, 1'b0, 8'h00, 32'h0, rd, e, lat);
        chk("rd00_id_again", rd, 32'h5157_0001);
`else
        txn(1'b0, 1'b1, 8'h00, 32'hFFFF_FFFF, rd, e, lat);
        chk("wr00_err", 32'(e), 32'd0);
        txn(1'b0, 1'b0, 8'h00, 32'h0, rd, e, lat);
        chk("rd00_data", rd, 32'hFFFF_FFFF);
`endif

        txn(1'b1, 1'b1, 8'h3C, 32'hCAFE_F00D, rd, e, lat);
        chk("zw_wr3c_latency", 32'(lat), 32'd0);
        chk("zw_wr3c_err", 32'(e), 32'd0);
        txn(1'b1, 1'b0, 8'h3C, 32'h0, rd, e, lat);
        chk("zw_rd3c_latency", 32'(lat), 32'd0);
        chk("zw_rd3c_rdata", rd, 32'hCAFE_F00D);
        txn(1'b1, 1'b0, 8'h40, 32'h0, rd, e, lat);
        chk("zw_rd40_err", 32'(e), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
